// File: rtl/spi_pkg.sv
// SPI mode encoding and sample-edge helper shared by the SPI slave blocks.
// Mode is {CPOL, CPHA}; sample edge is rising for modes 0 and 3.
package spi_pkg;

    typedef enum logic [1:0] {
        SPI_MODE0 = 2'd0,
        SPI_MODE1 = 2'd1,
        SPI_MODE2 = 2'd2,
        SPI_MODE3 = 2'd3
    } spi_mode_t;

    localparam logic EDGE_RISE = 1'b1;
    localparam logic EDGE_FALL = 1'b0;

    function automatic spi_mode_t spi_mode(input logic cpol, input logic cpha);
        return spi_mode_t'({cpol, cpha});
    endfunction

    function automatic logic sample_edge(input spi_mode_t mode);
        return (mode == SPI_MODE0 || mode == SPI_MODE3) ? EDGE_RISE : EDGE_FALL;
    endfunction

endpackage

// File: rtl/spi_edge_det.sv
// SPI pin sampling and edge detection in the system clock domain.
// SPI_WORD_SLAVE_SYNC_EN adds two-flop synchronisers ahead of the edge detector.
module spi_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk,
    input  logic spi_csb,
    input  logic spi_copi,
    input  logic cpol,
    output logic clk_rise,
    output logic clk_fall,
    output logic csb_q,
    output logic csb_fall,
    output logic copi_q,
    output logic primed
);

    logic clk_in;
    logic csb_in;
    logic copi_in;

`ifdef SPI_WORD_SLAVE_SYNC_EN
    localparam int PRIME = 3;

    logic [1:0] clk_s;
    logic [1:0] csb_s;
    logic [1:0] copi_s;

    // two-flop synchronisers for the asynchronous SPI pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s  <= {2{cpol}};
            csb_s  <= 2'b11;
            copi_s <= 2'b00;
        end else begin
            clk_s  <= {clk_s[0], spi_clk};
            csb_s  <= {csb_s[0], spi_csb};
            copi_s <= {copi_s[0], spi_copi};
        end
    end

    assign clk_in  = clk_s[1];
    assign csb_in  = csb_s[1];
    assign copi_in = copi_s[1];
`else
    localparam int PRIME = 1;

    assign clk_in  = spi_clk;
    assign csb_in  = spi_csb;
    assign copi_in = spi_copi;
`endif

    logic             clk_d;
    logic             clk_q;
    logic             csb_d;
    logic [PRIME-1:0] prime_sr;

    // sample pins, keep previous values, and flag when reset values have flushed out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_q    <= cpol;
            clk_d    <= cpol;
            csb_q    <= 1'b1;
            csb_d    <= 1'b1;
            copi_q   <= 1'b0;
            prime_sr <= '0;
        end else begin
            clk_q    <= clk_in;
            clk_d    <= clk_q;
            csb_q    <= csb_in;
            csb_d    <= csb_q;
            copi_q   <= copi_in;
            prime_sr <= PRIME'({prime_sr, 1'b1});
        end
    end

    assign clk_rise = clk_q & ~clk_d;
    assign clk_fall = ~clk_q & clk_d;
    assign csb_fall = csb_d & ~csb_q;
    assign primed   = prime_sr[PRIME-1];

endmodule

// File: rtl/spi_word_slave.sv
// SPI slave moving WIDTH-bit words, modes 0..3, with a one-word tx holding register.
// Build option SPI_WORD_SLAVE_SYNC_EN enables pin synchronisers in spi_edge_det.
module spi_word_slave
    import spi_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             SPI_clk,
    input  logic             SPI_csb,
    input  logic             SPI_copi,
    output logic             SPI_cipo,
    input  logic             SPI_CPOL,
    input  logic             SPI_CPHA,
    input  logic [WIDTH-1:0] Tx_data,
    input  logic             Tx_valid,
    output logic             Tx_ready,
    output logic [WIDTH-1:0] Rx_data,
    output logic             Rx_valid,
    output logic             Tx_underrun
);

    localparam int CW = $clog2(WIDTH);

    logic             sclk_rise;
    logic             sclk_fall;
    logic             csb_q;
    logic             csb_fall;
    logic             copi_q;
    logic             primed;
    logic             armed;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rx_sr;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] tx_next;

    spi_edge_det u_edge (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .spi_clk  (SPI_clk),
        .spi_csb  (SPI_csb),
        .spi_copi (SPI_copi),
        .cpol     (SPI_CPOL),
        .clk_rise (sclk_rise),
        .clk_fall (sclk_fall),
        .csb_q    (csb_q),
        .csb_fall (csb_fall),
        .copi_q   (copi_q),
        .primed   (primed)
    );

    logic on_rise;
    logic active;
    logic sample;
    logic shift;
    logic wrap;
    logic load;
    logic accept;

    assign on_rise = sample_edge(spi_mode(SPI_CPOL, SPI_CPHA)) == EDGE_RISE;
    assign active  = armed & ~csb_q;
    assign sample  = active & (on_rise ? sclk_rise : sclk_fall);
    assign shift   = active & (on_rise ? sclk_fall : sclk_rise);
    assign wrap    = sample & (cnt == CW'(WIDTH - 1));
    assign load    = (armed & csb_fall) | wrap;
    assign accept  = Tx_valid & ~hold_full;

    assign rx_next  = (LSB_FIRST != 0) ? {copi_q, rx_sr[WIDTH-1:1]}
                                       : {rx_sr[WIDTH-2:0], copi_q};
    assign tx_next  = (LSB_FIRST != 0) ? {1'b0, tx_sr[WIDTH-1:1]}
                                       : {tx_sr[WIDTH-2:0], 1'b0};
    assign SPI_cipo = (LSB_FIRST != 0) ? tx_sr[0] : tx_sr[WIDTH-1];
    assign Tx_ready = ~hold_full;

    // a frame already running at reset release is skipped until chip select idles high
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            armed <= 1'b0;
        end else if (primed && csb_q) begin
            armed <= 1'b1;
        end
    end

    // bit counter, receive shifter and completed-word strobe
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt      <= '0;
            rx_sr    <= '0;
            Rx_data  <= '0;
            Rx_valid <= 1'b0;
        end else begin
            Rx_valid <= wrap;
            if (csb_q) begin
                cnt <= '0;
            end else if (sample) begin
                cnt   <= wrap ? '0 : cnt + 1'b1;
                rx_sr <= rx_next;
            end
            if (wrap) begin
                Rx_data <= rx_next;
            end
        end
    end

    // transmit shifter: reload at frame start and word end, advance mid-word only
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tx_sr <= '0;
        end else if (load) begin
            tx_sr <= accept ? Tx_data : (hold_full ? hold : '0);
        end else if (shift && cnt != '0) begin
            tx_sr <= tx_next;
        end
    end

    // holding register; a word offered on a load cycle bypasses it
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (load) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= Tx_data;
            hold_full <= 1'b1;
        end
    end

    // sticky underrun, cleared only by a refill while deselected
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Tx_underrun <= 1'b0;
        end else if (load && !accept && !hold_full) begin
            Tx_underrun <= 1'b1;
        end else if (accept && csb_q) begin
            Tx_underrun <= 1'b0;
        end
    end

endmodule
